// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master CSR block: register map, field
// positions, reset values and the serial-clock state encoding.
package spi_master_pkg;

  localparam logic [2:0] REG_CONTROL  = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_MOSI     = 3'd2;
  localparam logic [2:0] REG_MISO     = 3'd3;
  localparam logic [2:0] REG_CS       = 3'd4;
  localparam logic [2:0] REG_CLK_DIV  = 3'd5;
  localparam logic [2:0] REG_LOOPBACK = 3'd6;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_LEN_LSB   = 8;
  localparam int unsigned CS_SEL_BIT     = 0;
  localparam int unsigned CS_MANUAL_BIT  = 16;
  localparam int unsigned LOOP_BIT       = 0;

  localparam logic [5:0]  LEN_RESET         = 6'd8;
  localparam logic [15:0] DIV_MIN           = 16'd2;
  localparam int unsigned DIV_RESET_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT_LOW  = 2'd1,
    ST_SHIFT_HIGH = 2'd2
  } spi_state_e;

  function automatic logic [5:0] eff_len(input logic [5:0] len);
    return ((len == 6'd0) || (len > 6'd32)) ? 6'd32 : len;
  endfunction

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Serial clock generator: half-period counter, rise/fall strobes and bit
// counting for one mode-0 transfer.
module spi_sck_gen
  import spi_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_div,
  input  logic [5:0]  i_len,
  output logic        o_sck,
  output logic        o_busy,
  output logic        o_rise,
  output logic        o_fall,
  output logic        o_last
);

  spi_state_e  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_div;
  logic [5:0]  r_bits;
  logic        r_sck;
  logic        w_tick;

  assign w_tick = (r_state != ST_IDLE) && (r_cnt == r_div - 16'd1);
  assign o_rise = w_tick && (r_state == ST_SHIFT_LOW);
  assign o_fall = w_tick && (r_state == ST_SHIFT_HIGH);
  assign o_last = o_fall && (r_bits == 6'd1);
  assign o_busy = (r_state != ST_IDLE);
  assign o_sck  = r_sck;

  // Strobes are asserted in the cycle before the edge so the top can act on
  // the same clock edge that moves spi_sck.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= DIV_MIN;
      r_bits  <= '0;
      r_sck   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SHIFT_LOW;
            r_cnt   <= '0;
            r_div   <= i_div;
            r_bits  <= i_len;
          end
        end
        ST_SHIFT_LOW: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_sck   <= 1'b1;
            r_state <= ST_SHIFT_HIGH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_SHIFT_HIGH: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_sck   <= 1'b0;
            r_bits  <= r_bits - 6'd1;
            r_state <= (r_bits == 6'd1) ? ST_IDLE : ST_SHIFT_LOW;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_sck   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_master_csr.sv
// Memory-mapped SPI master (mode 0, MSB first, 1-32 bits) with manual or
// automatic chip select and an internal loopback path.
module spi_master_csr
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [2:0]  bus_adr,
  input  logic [31:0] bus_dat_w,
  output logic [31:0] bus_dat_r,
  output logic        bus_ack,
  output logic        spi_sck,
  output logic        spi_csb,
  output logic        spi_sdo,
  input  logic        spi_sdi,
  output logic        spi_sdoenb
);

  logic        r_ack;
  logic [31:0] r_dat_r;
  logic [5:0]  r_len;
  logic [31:0] r_mosi;
  logic [31:0] r_miso;
  logic        r_sel;
  logic        r_manual;
  logic [15:0] r_div;
  logic        r_loop;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_sdo;
  logic        r_csb;

  logic        w_acc;
  logic        w_wr;
  logic        w_start;
  logic [5:0]  w_start_len;
  logic [31:0] w_tx_init;
  logic        w_busy;
  logic        w_rise;
  logic        w_fall;
  logic        w_last;
  logic        w_sck;
  logic        w_sin;
  logic        w_sel_nxt;
  logic        w_manual_nxt;
  logic        w_busy_nxt;
  logic [31:0] w_rdata;

  assign w_acc       = bus_stb & ~r_ack;
  assign w_wr        = w_acc & bus_we;
  assign w_start_len = eff_len(bus_dat_w[CTRL_LEN_LSB +: 6]);
  assign w_start     = w_wr && (bus_adr == REG_CONTROL) &&
                       bus_dat_w[CTRL_START_BIT] && !w_busy;
  // Left-align MOSI so the first bit to send is always bit 31.
  assign w_tx_init   = r_mosi << (6'd32 - w_start_len);
  assign w_sin       = r_loop ? r_sdo : spi_sdi;
  assign w_busy_nxt  = w_start | (w_busy & ~w_last);

  spi_sck_gen u_sck_gen (
    .clk     (core_clk),
    .rst_n   (core_rstn),
    .i_start (w_start),
    .i_div   (eff_div(r_div)),
    .i_len   (w_start_len),
    .o_sck   (w_sck),
    .o_busy  (w_busy),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_last  (w_last)
  );

  always_comb begin
    w_sel_nxt    = r_sel;
    w_manual_nxt = r_manual;
    if (w_wr && (bus_adr == REG_CS)) begin
      w_sel_nxt    = bus_dat_w[CS_SEL_BIT];
      w_manual_nxt = bus_dat_w[CS_MANUAL_BIT];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus_adr)
      REG_CONTROL:  w_rdata[CTRL_LEN_LSB +: 6] = r_len;
      REG_STATUS:   w_rdata[0] = ~w_busy;
      REG_MOSI:     w_rdata = r_mosi;
      REG_MISO:     w_rdata = r_miso;
      REG_CS: begin
        w_rdata[CS_SEL_BIT]    = r_sel;
        w_rdata[CS_MANUAL_BIT] = r_manual;
      end
      REG_CLK_DIV:  w_rdata[15:0] = r_div;
      REG_LOOPBACK: w_rdata[LOOP_BIT] = r_loop;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_ack    <= 1'b0;
      r_dat_r  <= '0;
      r_len    <= LEN_RESET;
      r_mosi   <= '0;
      r_sel    <= 1'b0;
      r_manual <= 1'b0;
      r_div    <= 16'(DIV_RESET);
      r_loop   <= 1'b0;
      r_csb    <= 1'b1;
    end else begin
      r_ack    <= w_acc;
      r_dat_r  <= (w_acc && !bus_we) ? w_rdata : '0;
      r_sel    <= w_sel_nxt;
      r_manual <= w_manual_nxt;
      r_csb    <= w_manual_nxt ? ~w_sel_nxt : ~(w_busy_nxt & w_sel_nxt);
      if (w_wr) begin
        case (bus_adr)
          REG_CONTROL:  r_len  <= bus_dat_w[CTRL_LEN_LSB +: 6];
          REG_MOSI:     r_mosi <= bus_dat_w;
          REG_CLK_DIV:  r_div  <= bus_dat_w[15:0];
          REG_LOOPBACK: r_loop <= bus_dat_w[LOOP_BIT];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_sdo  <= 1'b0;
      r_miso <= '0;
    end else if (w_start) begin
      r_tx  <= w_tx_init;
      r_sdo <= w_tx_init[31];
      r_rx  <= '0;
    end else begin
      if (w_rise) r_rx <= {r_rx[30:0], w_sin};
      // The final falling edge leaves spi_sdo on the last bit sent.
      if (w_fall && !w_last) begin
        r_tx  <= {r_tx[30:0], 1'b0};
        r_sdo <= r_tx[30];
      end
      if (w_last) r_miso <= r_rx;
    end
  end

  assign bus_ack    = r_ack;
  assign bus_dat_r  = r_dat_r;
  assign spi_sck    = w_sck;
  assign spi_csb    = r_csb;
  assign spi_sdoenb = r_csb;
  assign spi_sdo    = r_sdo;

endmodule

// File: tb/tb_spi_master_csr.sv
// Scoreboard bench for spi_master_csr: bus reads push expected data, a
// monitor checks each acknowledged read; pin timing is checked directly.
module tb_spi_master_csr;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;
  logic        bus_stb = 1'b0;
  logic        bus_we = 1'b0;
  logic [2:0]  bus_adr = '0;
  logic [31:0] bus_dat_w = '0;
  logic [31:0] bus_dat_r;
  logic        bus_ack;
  logic        spi_sck;
  logic        spi_csb;
  logic        spi_sdo;
  logic        spi_sdi;
  logic        spi_sdoenb;

  int checks = 0;
  int errors = 0;

  always #5 core_clk = ~core_clk;

  spi_master_csr #(.DIV_RESET(2)) dut (
    .core_clk   (core_clk),
    .core_rstn  (core_rstn),
    .bus_stb    (bus_stb),
    .bus_we     (bus_we),
    .bus_adr    (bus_adr),
    .bus_dat_w  (bus_dat_w),
    .bus_dat_r  (bus_dat_r),
    .bus_ack    (bus_ack),
    .spi_sck    (spi_sck),
    .spi_csb    (spi_csb),
    .spi_sdo    (spi_sdo),
    .spi_sdi    (spi_sdi),
    .spi_sdoenb (spi_sdoenb)
  );

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } txn_t;
  txn_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every acknowledged access pops one scoreboard entry.
  always @(negedge core_clk) begin
    if (core_rstn && bus_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = sb.pop_front();
        if (t.chk) check(t.name, bus_dat_r, t.exp);
      end
    end
  end

  task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                     input logic chk, input logic [31:0] exp, input string nm);
    txn_t t;
    @(posedge core_clk);
    #1;
    bus_stb = 1'b1; bus_we = we; bus_adr = adr; bus_dat_w = dat;
    t.chk = chk; t.exp = exp; t.name = nm;
    sb.push_back(t);
    @(posedge core_clk);
    #1;
    bus_stb = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
    bus(1'b1, adr, dat, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string nm);
    bus(1'b0, adr, 32'd0, 1'b1, exp, nm);
  endtask

  // Serial flash slave: 32 command/address bits, then data from address 0.
  logic [7:0] flash_mem [11] = '{8'h93, 8'h01, 8'h00, 8'h13, 8'h02, 8'h63,
                                 8'h57, 8'hB5, 8'h00, 8'h23, 8'h20};
  logic        flash_en = 1'b0;
  int          fl_n = 0;
  logic [31:0] fl_cmd = '0;
  logic        fl_bit;
  int          csb_hi_in_flash = 0;

  always @(negedge spi_sck or posedge spi_csb) begin
    if (spi_csb) fl_n = 0;
    else fl_n = fl_n + 1;
  end

  always @(posedge spi_sck) begin
    if (flash_en && !spi_csb && fl_n < 32) fl_cmd = {fl_cmd[30:0], spi_sdo};
  end

  always_comb begin
    int k;
    logic [7:0] b;
    fl_bit = 1'b0;
    k = fl_n - 32;
    if (fl_n >= 32 && k < 88) begin
      b = flash_mem[k / 8];
      fl_bit = b[7 - (k % 8)];
    end
  end

  assign spi_sdi = flash_en ? fl_bit : 1'b0;

  always @(negedge core_clk) begin
    if (flash_en && spi_csb) csb_hi_in_flash++;
  end

  initial begin
    int low;
    int rises;
    int run;
    int runs;
    int bad;
    int unstable;
    logic prev_sck;
    logic prev_sdo;
    logic prev_csb;
    logic [7:0] cap;
    logic [7:0] cmd_bytes [4];
    cmd_bytes = '{8'h03, 8'h00, 8'h00, 8'h00};

    // Reset state
    #12;
    check("rst_sck", {31'd0, spi_sck}, 32'd0);
    check("rst_csb", {31'd0, spi_csb}, 32'd1);
    check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
    check("rst_sdoenb", {31'd0, spi_sdoenb}, 32'd1);
    check("rst_ack", {31'd0, bus_ack}, 32'd0);
    check("rst_dat_r", bus_dat_r, 32'd0);
    @(posedge core_clk); #1 core_rstn = 1'b1;
    rd(3'd0, 32'h0000_0800, "rst_control");
    rd(3'd1, 32'd1, "rst_status");
    rd(3'd2, 32'd0, "rst_mosi");
    rd(3'd3, 32'd0, "rst_miso");
    rd(3'd4, 32'd0, "rst_cs");
    rd(3'd5, 32'd2, "rst_clkdiv");
    rd(3'd6, 32'd0, "rst_loopback");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'd0, "reg7");

    // Flash read with manual chip select
    wr(3'd4, 32'h0001_0001);
    flash_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(3'd2, {24'd0, cmd_bytes[i]});
      wr(3'd0, 32'h0000_0801);
      repeat (40) @(posedge core_clk);
    end
    rd(3'd1, 32'd1, "flash_cmd_done");
    for (int i = 0; i < 11; i++) begin
      wr(3'd2, 32'd0);
      wr(3'd0, 32'h0000_0801);
      repeat (40) @(posedge core_clk);
      rd(3'd3, {24'd0, flash_mem[i]}, $sformatf("flash_byte%0d", i));
    end
    check("flash_cmd", fl_cmd, 32'h0300_0000);
    check("flash_csb_low", csb_hi_in_flash, 32'd0);
    flash_en = 1'b0;

    // Loopback 32 bits, auto CS
    wr(3'd4, 32'h0000_0001);
    wr(3'd6, 32'd1);
    wr(3'd2, 32'hA5C3_0F96);
    low = 0;
    fork
      begin
        wr(3'd0, 32'h0000_2001);
        repeat (10) @(posedge core_clk);
        rd(3'd1, 32'd0, "loop_busy");
      end
      begin
        repeat (200) begin
          @(negedge core_clk);
          if (!spi_csb) low++;
        end
      end
    join
    check("loop_busy_cycles", low, 32'd128);
    rd(3'd1, 32'd1, "loop_done");
    rd(3'd3, 32'hA5C3_0F96, "loop_miso");

    // Divider 5, LEN 8, MOSI 0x81
    wr(3'd5, 32'd5);
    wr(3'd6, 32'd0);
    wr(3'd2, 32'h81);
    low = 0; run = 0; runs = 0; bad = 0; unstable = 0; cap = '0;
    prev_sck = spi_sck; prev_sdo = spi_sdo;
    fork
      wr(3'd0, 32'h0000_0801);
      begin
        repeat (150) begin
          @(negedge core_clk);
          if (!spi_csb) begin
            low++;
            if (run > 0 && spi_sck == prev_sck) run++;
            else begin
              if (run > 0) begin runs++; if (run != 5) bad++; end
              run = 1;
            end
            if (spi_sck && !prev_sck) begin
              cap = {cap[6:0], spi_sdo};
              if (spi_sdo !== prev_sdo) unstable++;
            end
          end else if (run > 0) begin
            runs++; if (run != 5) bad++;
            run = 0;
          end
          prev_sck = spi_sck; prev_sdo = spi_sdo;
        end
      end
    join
    check("div_cs_low", low, 32'd80);
    check("div_phase_count", runs, 32'd16);
    check("div_phase_len_bad", bad, 32'd0);
    check("div_sdo_unstable", unstable, 32'd0);
    check("div_bits_sent", {24'd0, cap}, 32'h81);
    rd(3'd3, 32'd0, "div_miso");

    // START while busy and MOSI write mid-transfer
    wr(3'd5, 32'd2);
    wr(3'd6, 32'd1);
    wr(3'd2, 32'h5A);
    low = 0; rises = 0; prev_csb = spi_csb;
    fork
      begin
        wr(3'd0, 32'h0000_0801);
        repeat (4) @(posedge core_clk);
        wr(3'd0, 32'h0000_0801);
        wr(3'd2, 32'hFF);
      end
      begin
        repeat (80) begin
          @(negedge core_clk);
          if (!spi_csb) low++;
          if (spi_csb && !prev_csb) rises++;
          prev_csb = spi_csb;
        end
      end
    join
    check("busy_start_cs_low", low, 32'd32);
    check("busy_start_done_rises", rises, 32'd1);
    rd(3'd1, 32'd1, "busy_start_done");
    rd(3'd3, 32'h5A, "busy_start_miso");
    wr(3'd0, 32'h0000_0801);
    repeat (40) @(posedge core_clk);
    rd(3'd3, 32'hFF, "next_xfer_miso");

    // Reset during bit 3 of a transfer
    wr(3'd0, 32'h0000_0801);
    repeat (15) @(posedge core_clk);
    #2;
    check("pre_rst_sck", {31'd0, spi_sck}, 32'd1);
    check("pre_rst_csb", {31'd0, spi_csb}, 32'd0);
    core_rstn = 1'b0;
    #1;
    check("midrst_csb", {31'd0, spi_csb}, 32'd1);
    check("midrst_sck", {31'd0, spi_sck}, 32'd0);
    check("midrst_sdo", {31'd0, spi_sdo}, 32'd0);
    check("midrst_sdoenb", {31'd0, spi_sdoenb}, 32'd1);
    repeat (2) @(posedge core_clk);
    #1 core_rstn = 1'b1;
    rd(3'd1, 32'd1, "midrst_status");
    rd(3'd3, 32'd0, "midrst_miso");
    rd(3'd5, 32'd2, "midrst_clkdiv");
    rd(3'd6, 32'd0, "midrst_loopback");

    repeat (3) @(posedge core_clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
